// File: rtl/deparser_pkg.sv
// Shared constants, state encoding and tail-width helper for the header write-back stage.
package deparser_pkg;
  localparam int          DP_NUM_HEADERS   = 2;
  localparam int          DP_MAX_HDR_WORDS = 8;
  localparam logic [31:0] NO_HEADER        = 32'hFFFF_FFFF;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] ZERO_ADDR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    DP_STATE_FREE    = 2'd0,
    DP_STATE_WRITING = 2'd1,
    DP_STATE_DONE    = 2'd2
  } dp_state_e;

  typedef struct packed {
    logic [3:0] width;
    logic       last;
  } dp_tail_t;

  // Bytes remaining from word_idx onward decide both the width and whether this is the final word.
  function automatic dp_tail_t dp_tail(input logic [31:0] len, input logic [31:0] word_idx);
    logic [31:0] rem;
    dp_tail_t    t;
    rem     = len - (word_idx << 2);
    t.last  = (rem <= 32'd4);
    t.width = t.last ? rem[3:0] : 4'd4;
    return t;
  endfunction
endpackage

// File: rtl/deparser_if.sv
// Control handshake, config strobe and memory write port of the deparser.
interface deparser_if;
  logic        start;
  logic        ready;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_width;
  logic [31:0] mem_data;
  logic        mod_start;
  logic [31:0] mod_hdr_id;
  logic [31:0] mod_hdr_len;

  modport master (
    input  start, mod_start, mod_hdr_id, mod_hdr_len,
    output ready, mem_ce, mem_we, mem_addr, mem_width, mem_data
  );

  modport slave (
    output start, mod_start, mod_hdr_id, mod_hdr_len,
    input  ready, mem_ce, mem_we, mem_addr, mem_width, mem_data
  );
endinterface

// File: rtl/deparser_core.sv
// Write-back engine: latches header images on start and streams present headers to memory word by word.
module deparser_core
  import deparser_pkg::*;
#(
  parameter int NUM_HEADERS   = DP_NUM_HEADERS,
  parameter int MAX_HDR_WORDS = DP_MAX_HDR_WORDS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [32*NUM_HEADERS-1:0]              hdr_addrs_i,
  input  logic [32*MAX_HDR_WORDS*NUM_HEADERS-1:0] hdr_data_i,
  deparser_if.master                             bus
);
  localparam int          H_W       = $clog2(NUM_HEADERS + 1);
  localparam int          K_W       = (MAX_HDR_WORDS > 1) ? $clog2(MAX_HDR_WORDS) : 1;
  localparam logic [31:0] MAX_BYTES = 32'(4 * MAX_HDR_WORDS);

  dp_state_e      r_state, w_state_next;
  logic [H_W-1:0] r_h, w_h_next;
  logic [K_W-1:0] r_k, w_k_next;
  logic           r_mem_ce, w_mem_ce_next;
  logic           r_mem_we, w_mem_we_next;
  logic [31:0]    r_mem_addr, w_mem_addr_next;
  logic [3:0]     r_mem_width, w_mem_width_next;
  logic [31:0]    r_mem_data, w_mem_data_next;
  logic           r_ready, w_ready_next;
  logic           w_latch, w_len_we;

  logic [31:0]    w_lens  [NUM_HEADERS];
  logic [31:0]    w_addrs [NUM_HEADERS];
  logic [31:0]    w_words [NUM_HEADERS];
  logic [31:0]    w_cur_len, w_cur_addr, w_cur_word;
  dp_tail_t       w_tail;

  generate
    for (genvar gi = 0; gi < NUM_HEADERS; gi++) begin : g_hdr
      logic [31:0] r_len;
      logic [31:0] r_addr;
      logic [31:0] r_img [MAX_HDR_WORDS];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          r_len <= ZERO_WORD;
        else if (w_len_we && bus.mod_hdr_id == 32'(gi))    r_len <= bus.mod_hdr_len;
      end

      always_ff @(posedge clk) begin
        if (w_latch) r_addr <= hdr_addrs_i[32*gi +: 32];
      end

      // Word 0 sits at the top of each header's slice of the image bus.
      for (genvar gk = 0; gk < MAX_HDR_WORDS; gk++) begin : g_word
        always_ff @(posedge clk) begin
          if (w_latch) r_img[gk] <= hdr_data_i[32*MAX_HDR_WORDS*gi + 32*(MAX_HDR_WORDS-gk) - 1 -: 32];
        end
      end

      assign w_lens[gi]  = r_len;
      assign w_addrs[gi] = r_addr;
      assign w_words[gi] = r_img[r_k];
    end
  endgenerate

  always_comb begin
    w_cur_len  = ZERO_WORD;
    w_cur_addr = NO_HEADER;
    w_cur_word = ZERO_WORD;
    for (int i = 0; i < NUM_HEADERS; i++) begin
      if (int'(r_h) == i) begin
        w_cur_len  = (w_lens[i] > MAX_BYTES) ? MAX_BYTES : w_lens[i];
        w_cur_addr = w_addrs[i];
        w_cur_word = w_words[i];
      end
    end
  end

  assign w_tail = dp_tail(w_cur_len, 32'(r_k));

  always_comb begin
    w_state_next     = r_state;
    w_h_next         = r_h;
    w_k_next         = r_k;
    w_mem_ce_next    = r_mem_ce;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_width_next = r_mem_width;
    w_mem_data_next  = r_mem_data;
    w_ready_next     = r_ready;
    w_latch          = 1'b0;
    w_len_we         = 1'b0;
    case (r_state)
      DP_STATE_FREE: begin
        if (bus.mod_start) begin
          w_len_we = (bus.mod_hdr_id < 32'(NUM_HEADERS));
        end else if (bus.start) begin
          w_latch      = 1'b1;
          w_h_next     = '0;
          w_k_next     = '0;
          w_ready_next = 1'b0;
          w_state_next = DP_STATE_WRITING;
        end
      end
      DP_STATE_WRITING: begin
        if (r_h == H_W'(NUM_HEADERS)) begin
          w_mem_ce_next = 1'b0;
          w_mem_we_next = 1'b0;
          w_ready_next  = 1'b1;
          w_state_next  = DP_STATE_DONE;
        end else if (w_cur_addr == NO_HEADER || w_cur_len == ZERO_WORD) begin
          w_mem_ce_next = 1'b0;
          w_mem_we_next = 1'b0;
          w_h_next      = r_h + H_W'(1);
          w_k_next      = '0;
        end else begin
          w_mem_ce_next    = 1'b1;
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = w_cur_addr + (32'(r_k) << 2);
          w_mem_width_next = w_tail.width;
          w_mem_data_next  = w_cur_word;
          if (w_tail.last) begin
            w_h_next = r_h + H_W'(1);
            w_k_next = '0;
          end else begin
            w_k_next = r_k + K_W'(1);
          end
        end
      end
      DP_STATE_DONE: begin
        w_mem_ce_next = 1'b0;
        w_mem_we_next = 1'b0;
        if (!bus.start) begin
          w_ready_next = 1'b0;
          w_state_next = DP_STATE_FREE;
        end
      end
      default: begin
        w_mem_ce_next = 1'b0;
        w_mem_we_next = 1'b0;
        w_state_next  = DP_STATE_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DP_STATE_FREE;
      r_h         <= '0;
      r_k         <= '0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ZERO_ADDR;
      r_mem_width <= 4'd0;
      r_mem_data  <= ZERO_WORD;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_h         <= w_h_next;
      r_k         <= w_k_next;
      r_mem_ce    <= w_mem_ce_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_width <= w_mem_width_next;
      r_mem_data  <= w_mem_data_next;
      r_ready     <= w_ready_next;
    end
  end

  assign bus.mem_ce    = r_mem_ce;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_width = r_mem_width;
  assign bus.mem_data  = r_mem_data;
  assign bus.ready     = r_ready;
endmodule

// File: rtl/deparser.sv
// Deparser top: flat port view of the write-back engine, bundling control and memory signals internally.
module deparser
  import deparser_pkg::*;
#(
  parameter int NUM_HEADERS   = DP_NUM_HEADERS,
  parameter int MAX_HDR_WORDS = DP_MAX_HDR_WORDS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_i,
  input  logic [32*NUM_HEADERS-1:0]               hdr_addrs_i,
  input  logic [32*MAX_HDR_WORDS*NUM_HEADERS-1:0] hdr_data_i,
  output logic                                    mem_ce_o,
  output logic                                    mem_we_o,
  output logic [31:0]                             mem_addr_o,
  output logic [3:0]                              mem_width_o,
  output logic [31:0]                             mem_data_o,
  output logic                                    ready_o,
  input  logic                                    mod_start_i,
  input  logic [31:0]                             mod_hdr_id_i,
  input  logic [31:0]                             mod_hdr_len_i
);
  deparser_if u_bus ();

  assign u_bus.start       = start_i;
  assign u_bus.mod_start   = mod_start_i;
  assign u_bus.mod_hdr_id  = mod_hdr_id_i;
  assign u_bus.mod_hdr_len = mod_hdr_len_i;

  deparser_core #(
    .NUM_HEADERS   (NUM_HEADERS),
    .MAX_HDR_WORDS (MAX_HDR_WORDS)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .hdr_addrs_i (hdr_addrs_i),
    .hdr_data_i  (hdr_data_i),
    .bus         (u_bus.master)
  );

  assign mem_ce_o    = u_bus.mem_ce;
  assign mem_we_o    = u_bus.mem_we;
  assign mem_addr_o  = u_bus.mem_addr;
  assign mem_width_o = u_bus.mem_width;
  assign mem_data_o  = u_bus.mem_data;
  assign ready_o     = u_bus.ready;
endmodule

// File: tb/tb_deparser.sv
// Directed bench for deparser: a byte-length model builds the expected write list and latency per run.
module tb_deparser;
  import deparser_pkg::*;

  localparam int NH = DP_NUM_HEADERS;
  localparam int MW = DP_MAX_HDR_WORDS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [32*NH-1:0]    hdr_addrs = '0;
  logic [32*MW*NH-1:0] hdr_data  = '0;

  deparser_if tb_bus ();

  deparser dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (tb_bus.start),
    .hdr_addrs_i   (hdr_addrs),
    .hdr_data_i    (hdr_data),
    .mem_ce_o      (tb_bus.mem_ce),
    .mem_we_o      (tb_bus.mem_we),
    .mem_addr_o    (tb_bus.mem_addr),
    .mem_width_o   (tb_bus.mem_width),
    .mem_data_o    (tb_bus.mem_data),
    .ready_o       (tb_bus.ready),
    .mod_start_i   (tb_bus.mod_start),
    .mod_hdr_id_i  (tb_bus.mod_hdr_id),
    .mod_hdr_len_i (tb_bus.mod_hdr_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] data;
  } wr_t;

  int unsigned m_len  [NH];
  logic [31:0] m_addr [NH];
  logic [31:0] m_word [NH][MW];
  wr_t         exp_q[$];
  wr_t         e;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_seen = 0;
  logic [31:0] last_addr = '0;
  int          lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every memory write the DUT issues is matched against the next one the model predicted.
  always @(negedge clk) begin
    if (rst && tb_bus.mem_ce) begin
      wr_seen++;
      last_addr = tb_bus.mem_addr;
      $display("write addr=%08h width=%0d data=%08h", tb_bus.mem_addr, tb_bus.mem_width, tb_bus.mem_data);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %08h, expected no write", tb_bus.mem_addr);
      end else begin
        e = exp_q.pop_front();
        check("mem_addr", tb_bus.mem_addr, e.addr);
        check("mem_width", {28'd0, tb_bus.mem_width}, {28'd0, e.width});
        check("mem_data", tb_bus.mem_data, e.data);
        check("mem_we", {31'd0, tb_bus.mem_we}, 32'd1);
      end
    end
  end

  function automatic int build_expect();
    int lat_m = 2;
    for (int h = 0; h < NH; h++) begin
      int L = (m_len[h] > 4*MW) ? 4*MW : int'(m_len[h]);
      if (m_addr[h] == NO_HEADER || L == 0) begin
        lat_m++;
      end else begin
        for (int k = 0; 4*k < L; k++) begin
          wr_t w;
          w.addr  = m_addr[h] + 32'(4*k);
          w.width = (L - 4*k >= 4) ? 4'd4 : 4'(L - 4*k);
          w.data  = m_word[h][k];
          exp_q.push_back(w);
          lat_m++;
        end
      end
    end
    return lat_m;
  endfunction

  task automatic load_hdrs();
    for (int h = 0; h < NH; h++) begin
      hdr_addrs[32*h +: 32] = m_addr[h];
      for (int k = 0; k < MW; k++)
        hdr_data[32*MW*h + 32*(MW-k) - 1 -: 32] = m_word[h][k];
    end
  endtask

  task automatic set_words(input int h, input logic [31:0] seed);
    for (int k = 0; k < MW; k++) m_word[h][k] = seed ^ (32'(k) * 32'h1111_1111);
  endtask

  task automatic cfg(input int id, input int unsigned len);
    @(negedge clk);
    tb_bus.mod_start   = 1'b1;
    tb_bus.mod_hdr_id  = 32'(id);
    tb_bus.mod_hdr_len = len;
    @(negedge clk);
    tb_bus.mod_start   = 1'b0;
    if (id < NH) m_len[id] = len;
  endtask

  // mod_at > 0 pulses a config write on that cycle of the run, which must not take effect.
  task automatic run(input string tag, input int mod_at, output int lat_o);
    int n;
    int exp_lat;
    load_hdrs();
    exp_lat = build_expect();
    wr_seen = 0;
    @(negedge clk);
    tb_bus.start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == mod_at) begin
        tb_bus.mod_start   = 1'b1;
        tb_bus.mod_hdr_id  = 32'd0;
        tb_bus.mod_hdr_len = 32'd4;
      end else begin
        tb_bus.mod_start = 1'b0;
      end
    end while (!tb_bus.ready && n < 200);
    tb_bus.mod_start = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    lat_o = n;
    @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    tb_bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_ready_release"}, {31'd0, tb_bus.ready}, 32'd0);
  endtask

  initial begin
    tb_bus.start       = 1'b0;
    tb_bus.mod_start   = 1'b0;
    tb_bus.mod_hdr_id  = '0;
    tb_bus.mod_hdr_len = '0;
    for (int h = 0; h < NH; h++) begin
      m_len[h]  = 0;
      m_addr[h] = NO_HEADER;
      set_words(h, 32'hA0B0_C0D0 + 32'(h));
    end
    repeat (3) @(negedge clk);
    check("rst_ce", {31'd0, tb_bus.mem_ce}, 32'd0);
    check("rst_ready", {31'd0, tb_bus.ready}, 32'd0);
    check("rst_addr", tb_bus.mem_addr, 32'd0);
    check("rst_width", {28'd0, tb_bus.mem_width}, 32'd0);
    check("rst_data", tb_bus.mem_data, 32'd0);
    rst = 1'b1;

    // T1: 14-byte header, second slot absent
    cfg(0, 14);
    m_addr[0] = 32'h100; m_addr[1] = NO_HEADER;
    set_words(0, 32'h0102_0304);
    run("t1", 0, lat);
    check("t1_lat_literal", lat, 7);
    check("t1_count", wr_seen, 4);
    check("t1_last_addr", last_addr, 32'h10C);

    // T2: two headers, 1-byte tail
    cfg(0, 8); cfg(1, 5);
    m_addr[0] = 32'h200; m_addr[1] = 32'h208;
    set_words(1, 32'hDEAD_BEEF);
    run("t2", 0, lat);
    check("t2_lat_literal", lat, 6);
    check("t2_count", wr_seen, 4);
    check("t2_last_addr", last_addr, 32'h20C);

    // T3: nothing present
    m_addr[0] = NO_HEADER; m_addr[1] = NO_HEADER;
    run("t3", 0, lat);
    check("t3_lat_literal", lat, 4);
    check("t3_count", wr_seen, 0);

    // T4: oversize length clamps to 8 words, zero length skipped, config during writing ignored
    cfg(0, 40); cfg(1, 0);
    m_addr[0] = 32'h0; m_addr[1] = 32'h80;
    run("t4a", 3, lat);
    check("t4a_lat_literal", lat, 11);
    check("t4a_count", wr_seen, 8);
    check("t4a_last_addr", last_addr, 32'h1C);
    run("t4b", 0, lat);
    check("t4b_count", wr_seen, 8);

    // T5: config and start together, config wins for that cycle
    m_addr[1] = 32'h90;
    load_hdrs();
    @(negedge clk);
    tb_bus.mod_start   = 1'b1;
    tb_bus.mod_hdr_id  = 32'd1;
    tb_bus.mod_hdr_len = 32'd6;
    tb_bus.start       = 1'b1;
    @(posedge clk);
    #1;
    tb_bus.mod_start = 1'b0;
    m_len[1] = 6;
    check("t5_no_write", {31'd0, tb_bus.mem_ce}, 32'd0);
    check("t5_no_ready", {31'd0, tb_bus.ready}, 32'd0);
    run("t5", 0, lat);
    check("t5_lat_literal", lat, 12);
    check("t5_last_addr", last_addr, 32'h94);

    // T6: address wrap past 2^32
    cfg(0, 8); cfg(1, 3);
    m_addr[0] = 32'hFFFF_FFFC; m_addr[1] = 32'h10;
    run("t6", 0, lat);
    check("t6_count", wr_seen, 3);
    check("t6_last_addr", last_addr, 32'h10);

    // T7: async reset between the 2nd and 3rd write
    cfg(0, 16);
    m_addr[0] = 32'h300; m_addr[1] = NO_HEADER;
    load_hdrs();
    void'(build_expect());
    wr_seen = 0;
    @(negedge clk);
    tb_bus.start = 1'b1;
    for (int i = 0; i < 50 && wr_seen < 2; i++) begin
      @(negedge clk);
      #1;
    end
    check("t7_writes_before_rst", wr_seen, 2);
    rst = 1'b0;
    #1;
    check("t7_ce_drop", {31'd0, tb_bus.mem_ce}, 32'd0);
    check("t7_we_drop", {31'd0, tb_bus.mem_we}, 32'd0);
    check("t7_addr_clr", tb_bus.mem_addr, 32'd0);
    exp_q.delete();
    for (int h = 0; h < NH; h++) m_len[h] = 0;
    tb_bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_ready_after", {31'd0, tb_bus.ready}, 32'd0);
    m_addr[0] = 32'h400; m_addr[1] = 32'h500;
    run("t7", 0, lat);
    check("t7_lat_literal", lat, 4);
    check("t7_count", wr_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/deparser.md
Name: deparser

Overview:
- Write-back stage opposite the header parser.
- Takes per-header packet offsets (parsed_hdrs, NO_HEADER = absent) and per-header byte images from the match-action stage.
- Writes each present header back into packet memory through the shared mem port, one word per cycle, then raises ready_o.
- Header lengths are runtime-configured through the same style of modify interface the parser uses.

Parameters:
- NUM_HEADERS, 2, number of header slots; taken from def.svh `NUM_HEADERS.
- MAX_HDR_WORDS, 8, 32-bit words buffered per header image (maximum header length 32 bytes).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start_i  input  1  request write-back; level, held until ready_o is seen.
- hdr_addrs_i  input  32*NUM_HEADERS  per-header packet address; slot h at [32h+31:32h]; `NO_HEADER means skip.
- hdr_data_i  input  32*MAX_HDR_WORDS*NUM_HEADERS  header images; header h word k at [256h + 32(MAX_HDR_WORDS-k) - 1 -: 32]; byte at lowest address in bits [31:24].
- mem_ce_o  output  1  memory enable.
- mem_we_o  output  1  write enable; always TRUE while mem_ce_o is TRUE.
- mem_addr_o  output  32  byte address.
- mem_width_o  output  4  bytes written: 4, or tail width 1..3.
- mem_data_o  output  32  write data, left-aligned; the first mem_width_o bytes from [31:24] downward are valid.
- ready_o  output  1  write-back complete.
- mod_start_i  input  1  config write strobe.
- mod_hdr_id_i  input  32  header slot to configure.
- mod_hdr_len_i  input  32  header length in bytes.

Behaviour:
- Reset (rst=0, async):
  - mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_width_o=0, mem_data_o=0, ready_o=0.
  - All hdr_lens=0, state=FREE, hdr cursor=0, word cursor=0.
- Reset mid-WRITING aborts immediately. No further memory writes occur, and lengths are cleared.
- Memory port is accept-every-cycle: each cycle with mem_ce_o=1 is exactly one completed write.
- State FREE:
  - If mod_start_i=1: hdr_lens[mod_hdr_id_i] <= mod_hdr_len_i. The write is ignored if id >= NUM_HEADERS. start_i is ignored that cycle (mod has priority).
  - Else if start_i=1: latch hdr_addrs_i and hdr_data_i into internal registers, set hdr cursor h=0, word k=0, ready_o<=0, go to WRITING. No write is issued on this edge.
- State WRITING (cursor h,k; L = min(hdr_lens[h], 4*MAX_HDR_WORDS); nw = ceil(L/4)):
  - If h == NUM_HEADERS: mem_ce_o<=0, mem_we_o<=0, ready_o<=1, go to DONE.
  - Else if addr[h] == NO_HEADER or L == 0: skip, h<=h+1, k<=0, mem_ce_o<=0. Costs one cycle.
  - Else drive a write:
    - mem_ce_o<=1, mem_we_o<=1, mem_addr_o<=addr[h]+4k, mem_data_o<=word k.
    - mem_width_o<=4, except on the last word (k = nw-1) where it is L-4k when L mod 4 != 0.
    - Advance: k<=k+1, or on the last word h<=h+1, k<=0.
- State DONE: ready_o held at 1 and outputs frozen (mem_ce_o=0). When start_i=0: ready_o<=0, go to FREE.
- Config changes are ignored outside FREE; latched images are stable during WRITING.
- Latency from start_i accepted to ready_o=1:
  - 1 + sum over present headers of nw + number of skipped slots + 1 cycles.
  - Writes are in strict order: header 0 before header 1, ascending addresses within a header.
- Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
- mem_width_o is never 0 while mem_ce_o=1.
- Unknown state encoding returns to FREE.

Decomposition:
- Add to def.svh, alongside the existing PS_STATE_* encodings: `DP_STATE_BUS and `DP_STATE_FREE/WRITING/DONE; `MAX_HDR_WORDS; `NO_HEADER, `TRUE/`FALSE and `ZERO_WORD/`ZERO_ADDR are reused.
- A single module is sufficient. An optional combinational helper, deparser_tail (length, word index -> width, last flag), is natural and shareable with future checksum logic.

Test Plan:
- Config hdr0 len=14; addrs {0x100, NO_HEADER}; start -> writes (0x100,w4), (0x104,w4), (0x108,w4), (0x10C,w2) with data = hdr0 words 0..3, then ready_o=1 (exact cycle count 1+4+1+1=7).
- hdr0 len=8 @0x200, hdr1 len=5 @0x208 -> writes 0x200/4, 0x204/4, 0x208/4, 0x20C/1 with tail data byte in [31:24]; ready_o then start_i=0 -> ready_o=0, FREE.
- Both addrs NO_HEADER -> no mem_ce_o pulse; ready_o after 1+2+1 cycles.
- len=40 (>32) @0x0 -> exactly 8 writes at width 4, last at 0x1C; len=0 -> skipped.
- mod_start_i and start_i asserted together -> length updated, no write that cycle; start accepted next cycle. mod_start_i during WRITING -> hdr_lens unchanged.
- rst=0 asserted asynchronously between the 2nd and 3rd write -> mem_ce_o drops without a clock edge; after release with start_i=0, FREE with all lengths 0.
